// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad stream decrypt engine.
//   state_t  : engine FSM states (IDLE, SHIFT, ABORT)
//   BYTE_W   : width of one emitted plaintext byte
//   bytes_of : number of bytes carried by a word of the given width
package otp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_of(input int unsigned word_w);
    return word_w / BYTE_W;
  endfunction

endpackage

// File: rtl/otp_byte_serializer.sv
// Word-to-byte serialiser for the OTP decrypt engine.
// Holds the decrypted word, walks a byte index and presents one byte at a
// time on a valid/ready interface.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture load_data and restart at byte 0
//   load_data   : decrypted word (WORD_W bits)
//   active      : engine is in SHIFT; enables out_valid
//   out_ready   : sink accepts the current byte
//   out_valid   : current byte valid
//   out_byte    : current byte (0 when not active)
//   accept      : byte handshake happens this cycle
//   last        : current byte is the final byte of the word
// Parameters: WORD_W (multiple of 8), MSB_FIRST (1 = MS byte first).
module otp_byte_serializer
  import otp_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              active,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_byte,
  output logic              accept,
  output logic              last
);

  localparam int unsigned BYTES = bytes_of(WORD_W);
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shifted;
  int unsigned       sel;

  assign out_valid = active;
  assign accept    = active & out_ready;
  assign last      = (idx_q == IDX_W'(BYTES - 1));

  // Byte lane chosen from the index; the output is held at 0 outside SHIFT
  // so nothing stale leaks to the sink between words.
  always_comb begin
    sel      = MSB_FIRST ? (BYTES - 1 - 32'(idx_q)) : 32'(idx_q);
    shifted  = data_q >> (sel * BYTE_W);
    out_byte = active ? shifted[BYTE_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      idx_q  <= '0;
    end else if (accept && !last) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/otp_stream_decrypt.sv
// One-time-pad decrypt/serialise engine.
// Joins one cipher word with one keypad word, XORs them and streams the
// plaintext as bytes. Aborts when the keypad runs dry.
// Optional feature macro: OTP_ZERO_KEY_CHECK_EN -- when defined, a zero
// keypad word is consumed and then halts the engine with err_zero_key set.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   cipher_valid/ready/data         : cipher word input handshake
//   key_valid/ready/data            : keypad word input handshake
//   key_exhausted                   : keypad source has no further words
//   out_valid/out_ready/out_byte    : plaintext byte output handshake
//   word_done                       : pulse after the last byte of a word
//   abort                           : sticky halt flag
//   err_zero_key                    : sticky zero-key flag
//   byte_count                      : bytes accepted by the sink (wraps)
module otp_stream_decrypt
  import otp_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cipher_valid,
  output logic              cipher_ready,
  input  logic [WORD_W-1:0] cipher_data,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [WORD_W-1:0] key_data,
  input  logic              key_exhausted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              word_done,
  output logic              abort,
  output logic              err_zero_key,
  output logic [CNT_W-1:0]  byte_count
);

  state_t state_q;
  logic   in_idle;
  logic   fire;
  logic   key_zero;
  logic   load;
  logic   accept;
  logic   last;

  assign in_idle = (state_q == ST_IDLE);

  // Each ready follows the other side's valid so both words are taken in
  // the same cycle or not at all.
  assign cipher_ready = in_idle & key_valid;
  assign key_ready    = in_idle & cipher_valid;
  assign fire         = in_idle & cipher_valid & key_valid;

`ifdef OTP_ZERO_KEY_CHECK_EN
  assign key_zero = (key_data == '0);
`else
  assign key_zero = 1'b0;
`endif

  assign load = fire & ~key_zero;

  otp_byte_serializer #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk       (clk),
    .rst       (reset),
    .load      (load),
    .load_data (cipher_data ^ key_data),
    .active    (state_q == ST_SHIFT),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .accept    (accept),
    .last      (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_done    <= 1'b0;
      abort        <= 1'b0;
      err_zero_key <= 1'b0;
      byte_count   <= '0;
    end else begin
      word_done <= 1'b0;
      if (accept) byte_count <= byte_count + CNT_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (fire) begin
            if (key_zero) begin
              state_q      <= ST_ABORT;
              abort        <= 1'b1;
              err_zero_key <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end else if (cipher_valid && key_exhausted) begin
            // fire is low with cipher_valid high, so key_valid is low here
            state_q <= ST_ABORT;
            abort   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (accept && last) begin
            state_q   <= ST_IDLE;
            word_done <= 1'b1;
          end
        end
        ST_ABORT: state_q <= ST_ABORT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_stream_decrypt.sv
// Self-checking bench: two engines (MSB-first and LSB-first) share stimulus;
// expected bytes come from a word-level XOR/shift reference.
module tb_otp_stream_decrypt;

  logic        clk = 1'b0;
  logic        reset;
  logic        cipher_valid, key_valid, key_exhausted, out_ready;
  logic [31:0] cipher_data, key_data;
  logic        cipher_ready_m, key_ready_m, out_valid_m, word_done_m;
  logic        abort_m, err_m;
  logic [7:0]  out_byte_m;
  logic [15:0] byte_count_m;
  logic        cipher_ready_l, key_ready_l, out_valid_l, word_done_l;
  logic        abort_l, err_l;
  logic [7:0]  out_byte_l;
  logic [15:0] byte_count_l;

  int unsigned pass_cnt  = 0;
  int unsigned chk_cnt   = 0;
  int unsigned fail_cnt  = 0;
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  otp_stream_decrypt #(.WORD_W(32), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .reset(reset),
    .cipher_valid(cipher_valid), .cipher_ready(cipher_ready_m), .cipher_data(cipher_data),
    .key_valid(key_valid), .key_ready(key_ready_m), .key_data(key_data),
    .key_exhausted(key_exhausted),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_byte(out_byte_m),
    .word_done(word_done_m), .abort(abort_m), .err_zero_key(err_m),
    .byte_count(byte_count_m)
  );

  otp_stream_decrypt #(.WORD_W(32), .MSB_FIRST(1'b0), .CNT_W(16)) dut_l (
    .clk(clk), .reset(reset),
    .cipher_valid(cipher_valid), .cipher_ready(cipher_ready_l), .cipher_data(cipher_data),
    .key_valid(key_valid), .key_ready(key_ready_l), .key_data(key_data),
    .key_exhausted(key_exhausted),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_byte(out_byte_l),
    .word_done(word_done_l), .abort(abort_l), .err_zero_key(err_l),
    .byte_count(byte_count_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plaintext byte number idx of word w in the given emit order.
  function automatic logic [31:0] ref_byte(input logic [31:0] w, input int unsigned idx,
                                           input bit msb);
    int unsigned sh;
    sh = msb ? (3 - idx) : idx;
    return (w >> (8 * sh)) & 32'hFF;
  endfunction

  // mode: 0 = sink always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // rst_after: nonzero -> reset the engines once that many bytes were taken.
  task automatic send_word(input logic [31:0] c, input logic [31:0] k,
                           input int unsigned delay, input int unsigned mode,
                           input bit exh, input int unsigned rst_after);
    logic [31:0] w;
    int unsigned i, cyc;
    bit rdy;
    w = c ^ k;
    @(negedge clk);
    cipher_valid = 1'b1; cipher_data = c;
    key_valid = 1'b0; key_exhausted = 1'b0; key_data = $urandom;
    for (int unsigned d = 0; d < delay; d++) begin
      #1;
      chk("wait_cipher_ready", cipher_ready_m, 0);
      chk("wait_out_valid", out_valid_m, 0);
      @(negedge clk);
    end
    key_valid = 1'b1; key_data = k; key_exhausted = exh;
    #1;
    chk("fire_cipher_ready", cipher_ready_m, 1);
    chk("fire_key_ready", key_ready_m, 1);
    @(negedge clk);
    cipher_valid = 1'b0; key_valid = 1'b0; key_exhausted = 1'b0;
    cipher_data = $urandom; key_data = $urandom;
    i = 0; cyc = 0;
    while (i < 4 && cyc < 64) begin
      if (rst_after != 0 && i == rst_after) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      #1;
      chk("out_valid_m", out_valid_m, 1);
      chk("out_valid_l", out_valid_l, 1);
      chk("byte_msb", out_byte_m, ref_byte(w, i, 1'b1));
      chk("byte_lsb", out_byte_l, ref_byte(w, i, 1'b0));
      chk("word_done_low", word_done_m, 0);
      chk("shift_key_ready", key_ready_m, 0);
      chk("byte_count_mid", byte_count_m, exp_count);
      if (rdy) begin
        i++;
        exp_count = (exp_count + 1) % 65536;
      end
      cyc++;
      @(negedge clk);
    end
    if (rst_after != 0) begin
      reset = 1'b1;
      #1;
      chk("rst_out_valid", out_valid_m, 0);
      chk("rst_out_byte", out_byte_m, 0);
      chk("rst_byte_count", byte_count_m, 0);
      chk("rst_word_done", word_done_m, 0);
      chk("rst_abort", abort_m, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_count = 0;
      return;
    end
    chk("bytes_taken", i, 4);
    out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("word_done_m", word_done_m, 1);
    chk("word_done_l", word_done_l, 1);
    chk("done_out_valid", out_valid_m, 0);
    chk("done_byte_count", byte_count_m, exp_count);
    chk("done_byte_count_l", byte_count_l, exp_count);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
  endtask

  initial begin
    reset = 1'b1;
    cipher_valid = 1'b0; key_valid = 1'b0; key_exhausted = 1'b0; out_ready = 1'b0;
    cipher_data = '0; key_data = '0;
    @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid_m, 0);
    chk("reset_out_byte", out_byte_m, 0);
    chk("reset_word_done", word_done_m, 0);
    chk("reset_abort", abort_m, 0);
    chk("reset_err", err_m, 0);
    chk("reset_byte_count", byte_count_m, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reference word, sink always ready: exact per-cycle timing.
    send_word(32'hDEADBEEF, 32'h0F0F0F0F, 0, 0, 1'b0, 0);
    // Key arrives after 10 waiting cycles; sink stalls 1,0,0,1.
    send_word($urandom, $urandom | 32'h1, 10, 1, 1'b0, 0);
    // key_exhausted high together with key_valid: key still used.
    send_word($urandom, $urandom | 32'h100, 0, 0, 1'b1, 0);
    for (int n = 0; n < 20; n++)
      send_word($urandom, $urandom | 32'h10000, $urandom_range(0, 3), 2, 1'b0, 0);

    // Reset after two bytes; following word must start again from byte 0.
    send_word(32'h01234567, 32'h89ABCDEF, 0, 0, 1'b0, 2);
    send_word(32'hCAFEF00D, 32'h5A5A5A5A, 1, 0, 1'b0, 0);

    // Zero keypad word.
`ifdef OTP_ZERO_KEY_CHECK_EN
    @(negedge clk);
    cipher_valid = 1'b1; cipher_data = 32'h13579BDF;
    key_valid = 1'b1; key_data = 32'h0;
    #1;
    chk("zk_cipher_ready", cipher_ready_m, 1);
    chk("zk_key_ready", key_ready_m, 1);
    @(negedge clk);
    cipher_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("zk_abort", abort_m, 1);
    chk("zk_err", err_m, 1);
    chk("zk_out_valid", out_valid_m, 0);
    @(negedge clk);
    #1;
    chk("zk_byte_count", byte_count_m, exp_count);
    chk("zk_err_held", err_m, 1);
    pulse_reset();
`else
    send_word(32'h13579BDF, 32'h0, 0, 0, 1'b0, 0);
    chk("zk_err_tied", err_m, 0);
    chk("zk_abort_low", abort_m, 0);
`endif

    // Keypad exhaustion with a cipher word pending.
    @(negedge clk);
    cipher_valid = 1'b1; cipher_data = $urandom;
    key_valid = 1'b0; key_exhausted = 1'b1;
    #1;
    chk("exh_key_ready_idle", key_ready_m, 1);
    chk("exh_cipher_ready_idle", cipher_ready_m, 0);
    @(negedge clk);
    #1;
    chk("exh_abort", abort_m, 1);
    chk("exh_abort_l", abort_l, 1);
    chk("exh_cipher_ready", cipher_ready_m, 0);
    chk("exh_key_ready", key_ready_m, 0);
    chk("exh_err", err_m, 0);
    @(negedge clk);
    key_valid = 1'b1; key_data = $urandom | 32'h1; key_exhausted = 1'b0;
    #1;
    chk("abort_cipher_ready", cipher_ready_m, 0);
    chk("abort_key_ready", key_ready_m, 0);
    @(negedge clk);
    #1;
    chk("abort_held", abort_m, 1);
    chk("abort_out_valid", out_valid_m, 0);
    chk("abort_byte_count", byte_count_m, exp_count);
    cipher_valid = 1'b0; key_valid = 1'b0;
    pulse_reset();
    #1;
    chk("post_reset_abort", abort_m, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/otp_stream_decrypt.md
Name: otp_stream_decrypt

Overview:
- Parametrised one-time-pad decrypt/serialise engine, the next generation of the fixed 32-bit XOR block plus word-to-byte FIFO pair.
- Joins one cipher word with one fresh keypad word (valid/ready on both), XORs them, and streams the result as bytes over a valid/ready output.
- Detects keypad exhaustion and aborts cleanly.
- Sits between the cipher-word source and the plaintext byte sink (file writer / UART).

Parameters:
- WORD_W, 32, cipher/key word width in bits; must be a multiple of 8, range 8..256.
- MSB_FIRST, 1, 1 = most-significant byte emitted first; 0 = least-significant first.
- CNT_W, 16, width of the emitted-byte counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cipher_valid  in  1  cipher word available.
- cipher_ready  out  1  cipher word accepted this cycle when high with cipher_valid.
- cipher_data  in  WORD_W  cipher word.
- key_valid  in  1  keypad word available.
- key_ready  out  1  keypad word consumed this cycle when high with key_valid.
- key_data  in  WORD_W  keypad word.
- key_exhausted  in  1  keypad source has no further words (level).
- out_valid  out  1  plaintext byte valid.
- out_ready  in  1  sink accepts byte.
- out_byte  out  8  plaintext byte.
- word_done  out  1  one-cycle pulse after the last byte of a word is accepted.
- abort  out  1  sticky; engine halted.
- err_zero_key  out  1  sticky; zero key word detected (feature-dependent).
- byte_count  out  CNT_W  total bytes accepted by the sink.

Behaviour:
- BYTES = WORD_W/8.
- States: IDLE, SHIFT, ABORT.
- Reset (async, any state, mid-word included): state=IDLE, data register=0, byte index=0, and all outputs 0 (out_valid, out_byte, word_done, abort, err_zero_key, byte_count). A partially emitted word is discarded.
- IDLE handshakes:
  - cipher_ready = key_valid; key_ready = cipher_valid.
  - fire = cipher_valid & key_valid. Both words are consumed in the same cycle, never one without the other.
- On fire:
  - Data register <= cipher_data ^ key_data; index <= 0; next state SHIFT.
  - Latency: first byte is valid in the cycle after fire.
- Exhaustion: in IDLE, if cipher_valid & !key_valid & key_exhausted -> ABORT and abort <= 1. Nothing is consumed.
  - If key_exhausted and key_valid are both high, the key is still used (valid wins).
- SHIFT:
  - out_valid = 1.
  - out_byte = byte[index] when MSB_FIRST=0; byte[BYTES-1-index] when MSB_FIRST=1.
  - out_byte is held stable while out_ready=0.
  - On out_valid & out_ready: byte_count += 1 (wraps modulo 2^CNT_W).
    - If index == BYTES-1: next state IDLE and word_done pulses in the next cycle.
    - Otherwise index += 1.
- Throughput: BYTES+1 cycles per word with out_ready held high. There is no IDLE bypass.
- ABORT:
  - Terminal until reset.
  - All readies 0, out_valid 0; abort and err_zero_key held.
- Ready outputs and out_valid are 0 outside IDLE/SHIFT respectively.
- BYTES=1 case: single SHIFT cycle per word; word_done pulses after every byte.

Optional Feature:
- Macro: OTP_ZERO_KEY_CHECK_EN.
- Defined:
  - A fire with key_data == 0 still completes the handshake, so both words are consumed.
  - The engine then goes to ABORT with err_zero_key <= 1 and abort <= 1.
  - No bytes are emitted for that word.
- Undefined:
  - A zero key is XORed normally, so the ciphertext passes through.
  - err_zero_key is tied to 0.

Decomposition:
- Package otp_pkg holds:
  - the state enum (IDLE, SHIFT, ABORT);
  - BYTE_W=8;
  - a function returning BYTES for a given WORD_W.
- Sub-module otp_byte_serializer handles the data register, byte index, MSB/LSB select and output handshake.
- Top level keeps the join, the FSM and the sticky flags.

Test Plan:
- WORD_W=32, MSB_FIRST=1, cipher=0xDEADBEEF, key=0x0F0F0F0F, out_ready=1 -> bytes D1,A2,B1,E0 on cycles fire+1..+4; word_done at fire+5; byte_count=4.
- Same word with MSB_FIRST=0 -> bytes E0,B1,A2,D1.
- out_ready toggles 1,0,0,1 during SHIFT -> out_byte stable while stalled; no byte lost or duplicated; byte_count matches the number of handshakes.
- Cipher valid, key_valid=0, key_exhausted=0 for 10 cycles, then key arrives -> no consumption while waiting; normal decrypt after. Cipher valid with key_exhausted=1 and no key -> abort=1 next cycle; readies stay 0.
- Reset asserted after the 2nd byte of a word -> all outputs 0 immediately; next word is emitted from byte 0.
- With OTP_ZERO_KEY_CHECK_EN, key=0x00000000 -> both words consumed; abort=1, err_zero_key=1, zero bytes emitted. Without the macro, the cipher bytes are passed unchanged.
